// File: rtl/attn_pv_accum_pkg.sv
// ---------------------------------------------------------------------------
// attn_pv_accum_pkg
//   Shared definitions for the attention probability x value path. The softmax
//   block and the output projection use the same definitions:
//     - Q-format constants for probabilities (Q1.15) and values (Q8.7)
//     - controller state encoding
//     - width rules for the product, the accumulator and the output shift
// ---------------------------------------------------------------------------
package attn_pv_accum_pkg;

    // Fractional bits of an unsigned Q1.15 probability.
    localparam int P_FRAC = 15;
    // Fractional bits of a signed Q8.7 value / context element.
    localparam int V_FRAC = 7;

    // A product carries P_FRAC+V_FRAC fractional bits. Dropping down to V_FRAC
    // for the output leaves P_FRAC bits to round away.
    localparam int OUT_SHIFT = (P_FRAC + V_FRAC) - V_FRAC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_MAC     = 2'd2,
        ST_OUT     = 2'd3
    } state_e;

    // Unsigned p_w x signed v_w: one extra bit absorbs the sign of the
    // zero-extended probability.
    function automatic int prod_width(input int p_w, input int v_w);
        return p_w + v_w + 1;
    endfunction

    // Smallest accumulator that cannot wrap while summing n products.
    function automatic int acc_width_min(input int p_w, input int v_w, input int n);
        return prod_width(p_w, v_w) + $clog2(n);
    endfunction

endpackage

// File: rtl/attn_pv_accum_prob_row_buf.sv
// ---------------------------------------------------------------------------
// prob_row_buf
//   Simple dual-port RAM holding one row of probabilities. It has one write
//   port and one read port. The read data is registered, so it arrives one
//   cycle after rd_addr.
//   Ports:
//     clk_i    clock
//     wr_en    write strobe
//     wr_addr  write address
//     wr_data  write data
//     rd_addr  read address
//     rd_data  registered read data, valid one cycle after rd_addr
// ---------------------------------------------------------------------------
module prob_row_buf #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/attn_pv_accum.sv
// ---------------------------------------------------------------------------
// attn_pv_accum
//   Captures one row of N unsigned Q1.15 probabilities from softmax. The
//   softmax block cannot be stalled. The block then produces the context
//   vector out[d] = sum_i p[i]*V[i][d] one dimension at a time. Each element
//   is rounded half-up and saturated to signed Q8.7, then offered on a
//   valid/ready stream.
//   Ports:
//     clk_i        clock
//     rst_i        synchronous active-high reset
//     start_i      begin a row (only honoured in IDLE)
//     p_valid_i    probability beat
//     p_data_i     probability, unsigned Q1.15
//     p_done_i     softmax end-of-row marker, used only for the error flag
//     v_addr_o     external V read address, i*D+d
//     v_rdata_i    V[i][d], one cycle after v_addr_o
//     out_valid_o  context element valid (held until out_ready_i)
//     out_data_o   context element, signed Q8.7
//     out_last_o   marks the element for d = D-1
//     out_ready_i  downstream accept
//     busy_o       controller not idle
//     err_o        sticky: p_done_i arrived on a beat other than the N-th
// ---------------------------------------------------------------------------
module attn_pv_accum
    import attn_pv_accum_pkg::*;
#(
    parameter int N     = 256,
    parameter int D     = 64,
    parameter int P_W   = 16,
    parameter int V_W   = 16,
    parameter int ACC_W = 40
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       p_valid_i,
    input  logic [P_W-1:0]             p_data_i,
    input  logic                       p_done_i,
    output logic [$clog2(N*D)-1:0]     v_addr_o,
    input  logic signed [V_W-1:0]      v_rdata_i,
    output logic                       out_valid_o,
    output logic signed [V_W-1:0]      out_data_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int NW     = (N > 1) ? $clog2(N) : 1;
    localparam int DW     = (D > 1) ? $clog2(D) : 1;
    localparam int AW     = $clog2(N * D);
    localparam int PROD_W = prod_width(P_W, V_W);

    localparam logic [NW-1:0] CNT_LAST = NW'(N - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(D - 1);
    localparam logic [AW-1:0] D_STEP   = AW'(D);

    localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(2 ** (OUT_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'((2 ** (V_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO  = ~SAT_HI;

    // Add half an output LSB, shift the extra fraction away, and clamp to V_W.
    function automatic logic signed [V_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + ROUND_K) >>> OUT_SHIFT;
        if (r > SAT_HI) begin
            r = SAT_HI;
        end else if (r < SAT_LO) begin
            r = SAT_LO;
        end
        return r[V_W-1:0];
    endfunction

    state_e state_q, state_d;

    logic [NW-1:0] cnt_q;      // capture write index, then MAC issue index
    logic [DW-1:0] d_q;
    logic [DW-1:0] d_nxt;
    logic          issue_q;    // MAC still issuing addresses for this d
    logic [AW-1:0] v_addr_q;

    logic          vld_p1, last_p1;
    logic          vld_p2, last_p2;
    logic          acc_done_q;

    logic [P_W-1:0]            prob_p1;
    logic signed [PROD_W-1:0]  prod_p2;
    logic signed [ACC_W-1:0]   acc_q;

    logic                  out_valid_q;
    logic signed [V_W-1:0] out_data_q;
    logic                  out_last_q;
    logic                  err_q;

    logic cap_beat;
    logic cap_last;
    logic out_hs;
    logic d_is_last;
    logic mac_enter;

    always_comb begin
        cap_beat  = (state_q == ST_CAPTURE) && p_valid_i;
        cap_last  = cap_beat && (cnt_q == CNT_LAST);
        out_hs    = (state_q == ST_OUT) && out_ready_i;
        d_is_last = (d_q == D_LAST);
        mac_enter = cap_last || (out_hs && !d_is_last);
        d_nxt     = d_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_i)     state_d = ST_CAPTURE;
            ST_CAPTURE: if (cap_last)    state_d = ST_MAC;
            ST_MAC:     if (acc_done_q)  state_d = ST_OUT;
            ST_OUT:     if (out_ready_i) state_d = d_is_last ? ST_IDLE : ST_MAC;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    prob_row_buf #(
        .DEPTH (N),
        .WIDTH (P_W),
        .AW    (NW)
    ) u_prob_row_buf (
        .clk_i   (clk_i),
        .wr_en   (cap_beat),
        .wr_addr (cnt_q),
        .wr_data (p_data_i),
        .rd_addr (cnt_q),
        .rd_data (prob_p1)
    );

    // Control: counters, address generator, valid pipeline, output stream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            d_q         <= '0;
            issue_q     <= 1'b0;
            v_addr_q    <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            vld_p2      <= 1'b0;
            last_p2     <= 1'b0;
            acc_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vld_p1     <= issue_q;
            last_p1    <= issue_q && (cnt_q == CNT_LAST);
            vld_p2     <= vld_p1;
            last_p2    <= last_p1;
            acc_done_q <= vld_p2 && last_p2;

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cnt_q <= '0;
                        d_q   <= '0;
                        err_q <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (p_valid_i) begin
                        // N is a power of two, so cnt_q wraps back to 0 on the
                        // N-th beat. That is the first MAC index.
                        cnt_q <= cnt_q + 1'b1;
                        if (p_done_i && (cnt_q != CNT_LAST)) begin
                            err_q <= 1'b1;
                        end
                        if (cnt_q == CNT_LAST) begin
                            d_q      <= '0;
                            v_addr_q <= '0;
                            issue_q  <= 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (issue_q) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            // Stop at the last address so it stays put through OUT.
                            issue_q <= 1'b0;
                        end else begin
                            v_addr_q <= v_addr_q + D_STEP;
                        end
                    end
                    if (acc_done_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= round_sat(acc_q);
                        out_last_q  <= d_is_last;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (!d_is_last) begin
                            d_q      <= d_nxt;
                            v_addr_q <= AW'(d_nxt);
                            cnt_q    <= '0;
                            issue_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // stage 1 -> stage 2: probability and V word arrive together; form product
    always_ff @(posedge clk_i) begin
        prod_p2 <= $signed({1'b0, prob_p1}) * v_rdata_i;
    end

    // stage 2 -> stage 3: accumulate; cleared whenever a dimension starts
    always_ff @(posedge clk_i) begin
        if (mac_enter) begin
            acc_q <= '0;
        end else if (vld_p2) begin
            acc_q <= acc_q + ACC_W'(prod_p2);
        end
    end

    assign v_addr_o    = v_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_attn_pv_accum.sv
module tb_attn_pv_accum;

    localparam int N = 4;
    localparam int D = 2;
    localparam int LAT = N + 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic              p_valid;
    logic [15:0]       p_data;
    logic              p_done;
    logic [2:0]        v_addr;
    logic signed [15:0] v_rdata;
    logic              out_valid;
    logic signed [15:0] out_data;
    logic              out_last;
    logic              rdy;
    logic              busy;
    logic              err;

    int vmem [N*D];

    int checks = 0;
    int errors = 0;

    attn_pv_accum #(
        .N     (N),
        .D     (D),
        .P_W   (16),
        .V_W   (16),
        .ACC_W (40)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .p_valid_i   (p_valid),
        .p_data_i    (p_data),
        .p_done_i    (p_done),
        .v_addr_o    (v_addr),
        .v_rdata_i   (v_rdata),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ready_i (rdy),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External V memory with one cycle of read latency.
    always @(posedge clk) v_rdata <= 16'(vmem[v_addr]);

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_v(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
        vmem[0] = a0; vmem[1] = a1; vmem[2] = a2; vmem[3] = a3;
        vmem[4] = a4; vmem[5] = a5; vmem[6] = a6; vmem[7] = a7;
    endtask

    // Starts a row and streams four beats with one gap after the second beat.
    // The task returns in the first MAC cycle.
    task automatic send_row(input string tag, input int p0, input int p1,
                            input int p2, input int p3, input int done_beat);
        int p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_up"}, int'(busy), 1);
        for (int b = 0; b < N; b++) begin
            p_valid = 1'b1;
            p_data  = 16'(p[b]);
            p_done  = (b == done_beat);
            @(negedge clk);
            if (b == 1) begin
                p_valid = 1'b0;
                p_done  = 1'b0;
                p_data  = 16'hBEEF;
                @(negedge clk);
            end
        end
        p_valid = 1'b0;
        p_done  = 1'b0;
        chk({tag, "_err"}, int'(err), (done_beat != N - 1) ? 1 : 0);
    endtask

    // Called from the first MAC cycle of a dimension. It waits for out_valid,
    // checks latency and data, optionally stalls, then handshakes.
    task automatic get_out(input string tag, input int exp_d, input int exp_last,
                           input int stall);
        int n;
        logic [2:0] a0;
        logic signed [15:0] d0;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, int'(out_valid), 1);
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_dat"}, int'(out_data), exp_d);
        chk({tag, "_last"}, int'(out_last), exp_last);
        a0 = v_addr;
        d0 = out_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"}, int'(out_valid), 1);
            chk({tag, "_hold_dat"}, int'(out_data), int'(d0));
            chk({tag, "_hold_addr"}, int'(v_addr), int'(a0));
        end
        rdy = 1'b1;
        @(negedge clk);
        chk({tag, "_drop"}, int'(out_valid), 0);
        if (exp_last != 0) chk({tag, "_busy_dn"}, int'(busy), 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        p_valid = 1'b0;
        p_data  = '0;
        p_done  = 1'b0;
        rdy     = 1'b1;
        set_v(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_vld",  int'(out_valid), 0);
        chk("rst_dat",  int'(out_data), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err",  int'(err), 0);
        chk("rst_addr", int'(v_addr), 0);

        // Beats while IDLE must be ignored.
        p_valid = 1'b1; p_data = 16'd12345; p_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        p_valid = 1'b0; p_done = 1'b0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_err", int'(err), 0);

        // One-hot probability selects row 0.
        set_v(100, -50, 999, 999, -999, 999, 999, 999);
        send_row("a", 32768, 0, 0, 0, 3);
        get_out("a0", 100, 0, 0);
        get_out("a1", -50, 1, 0);

        // Uniform weights with backpressure on the first element.
        set_v(128, -7, 256, -7, 384, -7, 512, -7);
        rdy = 1'b0;
        send_row("b", 8192, 8192, 8192, 8192, 3);
        get_out("b0", 320, 0, 5);
        get_out("b1", -7, 1, 0);

        // Round half up: 1.5 -> 2, -1.5 -> -1.
        set_v(3, -3, 500, 500, 500, 500, 500, 500);
        send_row("r", 16384, 0, 0, 0, 3);
        get_out("r0", 2, 0, 0);
        get_out("r1", -1, 1, 0);

        // Saturation at both rails.
        set_v(32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768);
        send_row("s", 32768, 32768, 32768, 32768, 3);
        get_out("s0", 32767, 0, 0);
        get_out("s1", -32768, 1, 0);

        // Early done flags an error, then reset lands during MAC of d=1.
        set_v(100, -50, 0, 0, 0, 0, 0, 0);
        send_row("e", 32768, 0, 0, 0, 1);
        get_out("e0", 100, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("e_mac_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_vld",  int'(out_valid), 0);
        chk("mrst_dat",  int'(out_data), 0);
        chk("mrst_last", int'(out_last), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_err",  int'(err), 0);
        chk("mrst_addr", int'(v_addr), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 9) chk("mrst_quiet", int'(out_valid), 0);
        end

        // Fresh row after reset.
        set_v(100, -50, 999, 999, -999, 999, 999, 999);
        send_row("f", 32768, 0, 0, 0, 3);
        get_out("f0", 100, 0, 0);
        get_out("f1", -50, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
